// File: rtl/i2s_tx.sv
// i2s_tx: captures one 16-bit sample per strobe and sends it as a
// burst-clocked mono I2S frame (L = R = sample), MSB first.
module i2s_tx #(
  parameter int BCLK_HALF = 10,
  parameter int SLOT_BITS = 16
) (
  input  logic        i_clk48,
  input  logic        i_rst48,
  input  logic [15:0] i_sample,
  input  logic        i_valid,
  input  logic        i_mute,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int NP = 2 * SLOT_BITS + 1;
  localparam int HW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int PW = $clog2(NP);
  localparam logic [HW-1:0] H_LAST = HW'(BCLK_HALF - 1);
  localparam logic [PW-1:0] P_SL = PW'(SLOT_BITS);
  localparam logic [PW-1:0] P_RL = PW'(2 * SLOT_BITS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NP - 1);

  typedef enum logic {
    IDLE,
    XMIT
  } state_t;

  state_t state, state_nx;

  logic [HW-1:0]        hcnt;
  logic                 phase;
  logic [PW-1:0]        pcnt;
  logic [15:0]          word_q;
  logic [15:0]          pend_word;
  logic                 pend_vld;
  logic [SLOT_BITS-1:0] sh;
  logic [15:0]          in_word;
  logic [15:0]          load_word;
  logic                 load;
  logic                 ovr_nx;
  logic                 per_end;
  logic                 frame_end;
  logic                 busy;

  function automatic logic [SLOT_BITS-1:0] to_slot(input logic [15:0] w);
    logic [SLOT_BITS-1:0] s;
    s = '0;
    s[SLOT_BITS-1 -: 16] = w;
    return s;
  endfunction

  assign in_word   = i_mute ? 16'h0000 : i_sample;
  assign busy      = (state == XMIT);
  assign per_end   = phase && (hcnt == H_LAST);
  assign frame_end = busy && per_end && (pcnt == P_LAST);

  assign o_busy  = busy;
  assign o_bclk  = busy && phase;
  assign o_lrclk = busy && (pcnt >= P_SL) && (pcnt <= P_RL);
  assign o_sdata = busy && (pcnt != '0) && sh[SLOT_BITS-1];

  // State register
  always_ff @(posedge i_clk48) begin
    if (i_rst48) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state, frame load and overrun decision
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_word = in_word;
    ovr_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          load     = 1'b1;
          state_nx = XMIT;
        end else if (pend_vld) begin
          load      = 1'b1;
          load_word = pend_word;
          state_nx  = XMIT;
        end
      end
      XMIT: begin
        ovr_nx = i_valid && pend_vld;
        if (frame_end) begin
          if (i_valid) begin
            load = 1'b1;
          end else if (pend_vld) begin
            load      = 1'b1;
            load_word = pend_word;
          end else begin
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  // Pending slot, shift register and bit-clock counters
  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      hcnt      <= '0;
      phase     <= 1'b0;
      pcnt      <= '0;
      word_q    <= '0;
      pend_word <= '0;
      pend_vld  <= 1'b0;
      sh        <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= ovr_nx;
      if (busy && i_valid && !frame_end) begin
        pend_vld  <= 1'b1;
        pend_word <= in_word;
      end else if (load) begin
        pend_vld <= 1'b0;
      end
      if (load) begin
        word_q <= load_word;
        sh     <= to_slot(load_word);
        hcnt   <= '0;
        phase  <= 1'b0;
        pcnt   <= '0;
      end else if (busy) begin
        if (per_end) begin
          hcnt  <= '0;
          phase <= 1'b0;
          if (pcnt == P_LAST) pcnt <= '0;
          else                pcnt <= pcnt + 1'b1;
          if (pcnt == P_SL)       sh <= to_slot(word_q);
          else if (pcnt != '0)    sh <= sh << 1;
        end else if (hcnt == H_LAST) begin
          hcnt  <= '0;
          phase <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx, default build plus a
// 24-bit-slot / fast-BCLK build.
module tb_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] sample;
  logic        valid, valid2, mute;
  logic        bclk, lrclk, sdata, busy, ovr;
  logic        bclk2, lrclk2, sdata2, busy2, ovr2;

  i2s_tx dut (
    .i_clk48  (clk),
    .i_rst48  (rst),
    .i_sample (sample),
    .i_valid  (valid),
    .i_mute   (mute),
    .o_bclk   (bclk),
    .o_lrclk  (lrclk),
    .o_sdata  (sdata),
    .o_busy   (busy),
    .o_overrun(ovr)
  );

  i2s_tx #(.BCLK_HALF(2), .SLOT_BITS(24)) dut2 (
    .i_clk48  (clk),
    .i_rst48  (rst),
    .i_sample (sample),
    .i_valid  (valid2),
    .i_mute   (mute),
    .o_bclk   (bclk2),
    .o_lrclk  (lrclk2),
    .o_sdata  (sdata2),
    .o_busy   (busy2),
    .o_overrun(ovr2)
  );

  int n_chk = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference frame built by bit index: p=0 zero, then two slots
  task automatic frame_chk(input string tag, input logic [63:0] d,
                           input logic [63:0] l, input int sb,
                           input logic [15:0] w);
    logic [31:0] slot;
    logic [63:0] ed, el;
    slot = {w, 16'h0000} >> (32 - sb);
    ed = '0;
    el = '0;
    for (int p = 1; p <= sb; p++) ed[p] = slot[sb-p];
    for (int p = sb + 1; p <= 2 * sb; p++) ed[p] = slot[2*sb-p];
    for (int p = sb; p < 2 * sb; p++) el[p] = 1'b1;
    chk({tag, "_sdata"}, d, ed);
    chk({tag, "_lrclk"}, l, el);
  endtask

  int rc = 0;
  logic pb = 1'b0;
  logic [63:0] fd = '0, fl = '0;

  // Default build: sample data/word select on each BCLK rise
  always @(negedge clk) begin
    if (rst) begin
      rc = 0; pb = 1'b0; fd = '0; fl = '0;
    end else begin
      if (bclk && !pb) begin
        fd[rc] = sdata;
        fl[rc] = lrclk;
        rc++;
        if (rc == 33) begin
          if (exp_q.size() == 0) chk("sb_empty", 1, 0);
          else frame_chk("frm", fd, fl, 16, exp_q.pop_front());
          rc = 0; fd = '0; fl = '0;
        end
      end
      pb = bclk;
      if (ovr) ovr_cnt++;
    end
  end

  int rc2 = 0;
  logic pb2 = 1'b0;
  logic [63:0] fd2 = '0, fl2 = '0;

  // 24-bit-slot build monitor
  always @(negedge clk) begin
    if (rst) begin
      rc2 = 0; pb2 = 1'b0; fd2 = '0; fl2 = '0;
    end else begin
      if (bclk2 && !pb2) begin
        fd2[rc2] = sdata2;
        fl2[rc2] = lrclk2;
        rc2++;
        if (rc2 == 49) begin
          if (exp2_q.size() == 0) chk("sb2_empty", 1, 0);
          else frame_chk("frm2", fd2, fl2, 24, exp2_q.pop_front());
          rc2 = 0; fd2 = '0; fl2 = '0;
        end
      end
      pb2 = bclk2;
    end
  end

  task automatic send(input logic [15:0] w, input logic m);
    sample = w; mute = m; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; mute = 1'b0;
  endtask

  task automatic send2(input logic [15:0] w);
    sample = w; valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  task automatic busy_run(input bit sel, output int n);
    n = 0;
    while ((sel ? busy2 : busy) && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n, idle, o0;
  logic [15:0] rw;

  initial begin
    rst = 1'b1; valid = 1'b0; valid2 = 1'b0; mute = 1'b0; sample = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {bclk, lrclk, sdata, busy, ovr,
                    bclk2, lrclk2, sdata2, busy2, ovr2}, 0);
    rst = 1'b0;
    @(negedge clk);

    exp_q.push_back(16'hA5C3);
    send(16'hA5C3, 1'b0);
    chk("busy_start", busy, 1);
    busy_run(1'b0, n);
    chk("len_a5c3", n, 660);
    chk("idle_out", {bclk, lrclk, sdata, ovr}, 0);

    exp_q.push_back(16'h0000);
    send(16'hFFFF, 1'b1);
    busy_run(1'b0, n);
    chk("len_mute", n, 660);

    o0 = ovr_cnt;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h0001);
    send(16'h0001, 1'b0);
    idle = 0;
    for (int i = 0; i < 999; i++) begin
      if (!busy) idle++;
      @(negedge clk);
    end
    if (!busy) idle++;
    chk("idle_gap", idle, 340);
    exp_q.push_back(16'h0002);
    send(16'h0002, 1'b0);
    repeat (99) @(negedge clk);
    exp_q.push_back(16'h1234);
    send(16'h1234, 1'b0);
    busy_run(1'b0, n);
    chk("b2b_len", n, 1220);
    chk("no_ovr", ovr_cnt - o0, 0);

    o0 = ovr_cnt;
    repeat (5) @(negedge clk);
    exp_q.push_back(16'h1111);
    send(16'h1111, 1'b0);
    repeat (50) @(negedge clk);
    exp_q.push_back(16'h2222);
    send(16'h2222, 1'b0);
    chk("ovr_early", ovr, 0);
    repeat (50) @(negedge clk);
    exp_q[exp_q.size()-1] = 16'h3333;
    send(16'h3333, 1'b0);
    chk("ovr_pulse", ovr, 1);
    @(negedge clk);
    chk("ovr_clear", ovr, 0);
    busy_run(1'b0, n);
    chk("ovr_len", n, 1217);
    chk("ovr_cnt", ovr_cnt - o0, 1);

    repeat (5) @(negedge clk);
    exp_q.push_back(16'hBEEF);
    send(16'hBEEF, 1'b0);
    repeat (20) @(negedge clk);
    exp_q.push_back(16'hCAFE);
    send(16'hCAFE, 1'b0);
    repeat (183) @(negedge clk);
    chk("p10_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort", {bclk, lrclk, sdata, busy, ovr}, 0);
    rst = 1'b0;
    exp_q.delete();
    n = 0;
    repeat (2000) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("no_frame", n, 0);

    exp_q.push_back(16'h5555);
    send(16'h5555, 1'b0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst5_%0d", i), {bclk, lrclk, sdata, busy, ovr}, 0);
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst", busy, 0);

    for (int k = 0; k < 3; k++) begin
      rw = 16'($urandom);
      exp_q.push_back(rw);
      send(rw, 1'b0);
      busy_run(1'b0, n);
      chk($sformatf("rnd_len%0d", k), n, 660);
      repeat (7) @(negedge clk);
    end

    exp2_q.push_back(16'h8001);
    send2(16'h8001);
    chk("b2_start", busy2, 1);
    busy_run(1'b1, n);
    chk("len2", n, 196);
    repeat (5) @(negedge clk);

    chk("q1_empty", exp_q.size(), 0);
    chk("q2_empty", exp2_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
